// File: rtl/sprite_plot_arbiter.sv
// Round-robin arbiter that grants one sprite datapath at a time and walks its box
// row-major, emitting one registered VGA plot per cycle.
module sprite_plot_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned SCREEN_W  = 320,
  parameter int unsigned SCREEN_H  = 240
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     erase_req,
  input  logic [9*NUM_REQ-1:0]   base_x,
  input  logic [8*NUM_REQ-1:0]   base_y,
  input  logic [6*NUM_REQ-1:0]   size_w,
  input  logic [6*NUM_REQ-1:0]   size_h,
  input  logic [3*NUM_REQ-1:0]   colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    DRAW,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   pick, cand;
  logic               found;

  logic [8:0]         bx, bx_next;
  logic [7:0]         by, by_next;
  logic [5:0]         w, w_next, h, h_next;
  logic [5:0]         col, col_next, row, row_next;
  logic [2:0]         ink, ink_next;

  logic [NUM_REQ-1:0] grant_next, done_next;
  logic               busy_next, plot_next;
  logic [8:0]         x_next;
  logic [7:0]         y_next;
  logic [2:0]         c_next;

  logic [9:0]         px;
  logic [8:0]         py;
  logic               on_screen;

  logic [8:0]         bx_arr  [NUM_REQ];
  logic [7:0]         by_arr  [NUM_REQ];
  logic [5:0]         w_arr   [NUM_REQ];
  logic [5:0]         h_arr   [NUM_REQ];
  logic [2:0]         col_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign bx_arr[g]  = base_x[9*g +: 9];
    assign by_arr[g]  = base_y[8*g +: 8];
    assign w_arr[g]   = size_w[6*g +: 6];
    assign h_arr[g]   = size_h[6*g +: 6];
    assign col_arr[g] = colour[3*g +: 3];
  end

  // Scan starts one past the last winner so the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Sums are one bit wider than the screen coordinates so overflow past 511/255 is still clipped.
  assign px        = {1'b0, bx} + 10'(col);
  assign py        = {1'b0, by} + 9'(row);
  assign on_screen = (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    bx_next    = bx;
    by_next    = by;
    w_next     = w;
    h_next     = h;
    ink_next   = ink;
    col_next   = col;
    row_next   = row;
    grant_next = grant;
    done_next  = '0;
    plot_next  = 1'b0;
    x_next     = vga_x;
    y_next     = vga_y;
    c_next     = vga_colour;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_next       = LATCH;
          ptr_next         = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
        end
      end
      LATCH: begin
        bx_next    = bx_arr[ptr];
        by_next    = by_arr[ptr];
        w_next     = w_arr[ptr];
        h_next     = h_arr[ptr];
        ink_next   = erase_req[ptr] ? BG_COLOUR : col_arr[ptr];
        col_next   = '0;
        row_next   = '0;
        state_next = (w_arr[ptr] == '0 || h_arr[ptr] == '0) ? DONE : DRAW;
      end
      DRAW: begin
        x_next    = px[8:0];
        y_next    = py[7:0];
        c_next    = ink;
        plot_next = on_screen;
        if (col == w - 6'd1) begin
          col_next = '0;
          row_next = row + 6'd1;
          if (row == h - 6'd1) begin
            state_next = DONE;
          end
        end else begin
          col_next = col + 6'd1;
        end
      end
      DONE: begin
        done_next  = grant;
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= PTR_W'(NUM_REQ - 1);
      bx         <= '0;
      by         <= '0;
      w          <= '0;
      h          <= '0;
      ink        <= '0;
      col        <= '0;
      row        <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      bx         <= bx_next;
      by         <= by_next;
      w          <= w_next;
      h          <= h_next;
      ink        <= ink_next;
      col        <= col_next;
      row        <= row_next;
      grant      <= grant_next;
      done       <= done_next;
      busy       <= busy_next;
      vga_plot   <= plot_next;
      vga_x      <= x_next;
      vga_y      <= y_next;
      vga_colour <= c_next;
    end
  end

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Bench for sprite_plot_arbiter: table of single boxes plus round-robin and reset sequences,
// with a pixel scoreboard fed by a reference model.
module tb_sprite_plot_arbiter;

  localparam int unsigned N = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req, erase_req, grant, done;
  logic [9*N-1:0]   base_x;
  logic [8*N-1:0]   base_y;
  logic [6*N-1:0]   size_w, size_h;
  logic [3*N-1:0]   colour;
  logic             busy, vga_plot;
  logic [8:0]       vga_x;
  logic [7:0]       vga_y;
  logic [2:0]       vga_colour;

  sprite_plot_arbiter #(
    .NUM_REQ  (N),
    .BG_COLOUR(3'b000),
    .SCREEN_W (320),
    .SCREEN_H (240)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .erase_req (erase_req),
    .base_x    (base_x),
    .base_y    (base_y),
    .size_w    (size_w),
    .size_h    (size_h),
    .colour    (colour),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int unsigned r;
    logic [8:0]  bx;
    logic [7:0]  by;
    logic [5:0]  w;
    logic [5:0]  h;
    logic [2:0]  c;
    logic        e;
    int unsigned exp_plots;
    int unsigned exp_lat;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   plots_seen = 0;
  pix_t sb[$];
  pix_t exp_pix;
  vec_t tv[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not observed as required", name);
  endtask

  // Every plotted pixel must match the oldest outstanding expected pixel.
  always @(negedge clock) begin
    if (vga_plot === 1'b1) begin
      plots_seen++;
      if (sb.size() == 0) begin
        fail("unexpected_plot");
      end else begin
        exp_pix = sb.pop_front();
        check("plot_pixel", {vga_x, vga_y, vga_colour}, exp_pix);
      end
    end
  end

  task automatic push_box(input logic [8:0] bx, input logic [7:0] by,
                          input logic [5:0] w, input logic [5:0] h, input logic [2:0] c);
    for (int r = 0; r < int'(h); r++) begin
      for (int q = 0; q < int'(w); q++) begin
        int x;
        int y;
        x = int'(bx) + q;
        y = int'(by) + r;
        if (x < 320 && y < 240) sb.push_back({9'(x), 8'(y), c});
      end
    end
  endtask

  task automatic set_slot(input int unsigned s, input logic [8:0] bx, input logic [7:0] by,
                          input logic [5:0] w, input logic [5:0] h, input logic [2:0] c,
                          input logic e);
    base_x[9*s +: 9] = bx;
    base_y[8*s +: 8] = by;
    size_w[6*s +: 6] = w;
    size_h[6*s +: 6] = h;
    colour[3*s +: 3] = c;
    erase_req[s]     = e;
  endtask

  task automatic run_box(input vec_t v);
    int unsigned cyc;
    logic        got;
    @(negedge clock);
    set_slot(v.r, v.bx, v.by, v.w, v.h, v.c, v.e);
    req        = '0;
    req[v.r]   = 1'b1;
    plots_seen = 0;
    push_box(v.bx, v.by, v.w, v.h, v.e ? 3'b000 : v.c);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (grant != '0) got = 1'b1;
    end
    if (!got) begin
      fail("grant_timeout");
      req = '0;
      sb.delete();
      return;
    end
    check("grant_onehot", grant, 64'(1) << v.r);
    check("busy_in_box", busy, 1);
    // LATCH has sampled by now; disturbing the inputs must not affect the box.
    @(negedge clock);
    req[v.r] = 1'b0;
    set_slot(v.r, 9'h1ff, 8'hff, 6'h3f, 6'h3f, ~v.c, ~v.e);
    cyc = 1;
    while (done == '0 && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    if (done == '0) begin
      fail("done_timeout");
    end else begin
      check("done_latency", cyc, v.exp_lat);
      check("done_onehot", done, 64'(1) << v.r);
      check("plot_count", plots_seen, v.exp_plots);
      check("scoreboard_drained", sb.size(), 0);
      check("grant_clear_at_done", grant, 0);
    end
    @(negedge clock);
    check("done_pulse_width", done, 0);
    check("busy_idle", busy, 0);
    sb.delete();
  endtask

  // Serves pending requests and checks the order of grant rises and done pulses.
  task automatic serve(input int n_exp, input logic [4*N-1:0] seq, input bit drop_on_done,
                       input string tag);
    int         ng;
    int         nd;
    logic [N-1:0] prev;
    ng   = 0;
    nd   = 0;
    prev = grant;
    for (int c = 0; c < 100 && nd < n_exp; c++) begin
      @(negedge clock);
      if (prev == '0 && grant != '0) begin
        if (ng < n_exp) check({tag, "_grant_order"}, grant, seq[N*ng +: N]);
        ng++;
      end
      if (done != '0) begin
        if (nd < n_exp) check({tag, "_done_order"}, done, seq[N*nd +: N]);
        nd++;
        if (drop_on_done) req = req & ~done;
      end
      prev = grant;
    end
    req = '0;
    check({tag, "_done_count"}, nd, n_exp);
    repeat (3) @(negedge clock);
    check({tag, "_scoreboard_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    erase_req = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int got_plots;
    reset     = 1'b1;
    req       = '0;
    erase_req = '0;
    base_x    = '0;
    base_y    = '0;
    size_w    = '0;
    size_h    = '0;
    colour    = '0;

    tv[0] = '{0, 9'd10,  8'd20,  6'd2, 6'd2, 3'd5, 1'b0, 4, 6};
    tv[1] = '{0, 9'd10,  8'd20,  6'd2, 6'd2, 3'd5, 1'b1, 4, 6};
    tv[2] = '{1, 9'd5,   8'd5,   6'd0, 6'd3, 3'd4, 1'b0, 0, 2};
    tv[3] = '{2, 9'd318, 8'd7,   6'd4, 6'd1, 3'd3, 1'b0, 2, 6};
    tv[4] = '{3, 9'd100, 8'd238, 6'd2, 6'd3, 3'd2, 1'b0, 4, 8};
    tv[5] = '{1, 9'd0,   8'd0,   6'd1, 6'd1, 3'd7, 1'b0, 1, 3};
    tv[6] = '{2, 9'd300, 8'd230, 6'd3, 6'd0, 3'd1, 1'b0, 0, 2};
    tv[7] = '{3, 9'd50,  8'd60,  6'd3, 6'd2, 3'd6, 1'b0, 6, 8};
    tv[8] = '{0, 9'd319, 8'd239, 6'd2, 6'd2, 3'd3, 1'b0, 1, 6};

    repeat (3) @(negedge clock);
    check("reset_grant", grant, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_plot", vga_plot, 0);
    check("reset_xyc", {vga_x, vga_y, vga_colour}, 0);
    reset = 1'b0;

    foreach (tv[i]) run_box(tv[i]);

    // Two requesters held continuously alternate.
    do_reset();
    @(negedge clock);
    set_slot(0, 9'd30, 8'd40, 6'd1, 6'd1, 3'd1, 1'b0);
    set_slot(2, 9'd60, 8'd70, 6'd1, 6'd1, 3'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_box(9'd30, 8'd40, 6'd1, 6'd1, 3'd1);
      else            push_box(9'd60, 8'd70, 6'd1, 6'd1, 3'd2);
    end
    req = 4'b0101;
    serve(4, 16'h4141, 1'b0, "rr");

    // Reset during the third DRAW cycle of a 4x4 box aborts it silently.
    do_reset();
    @(negedge clock);
    set_slot(0, 9'd20, 8'd30, 6'd4, 6'd4, 3'd5, 1'b0);
    push_box(9'd20, 8'd30, 6'd4, 6'd4, 3'd5);
    req = 4'b0001;
    got_plots = 0;
    for (int c = 0; c < 20 && got_plots < 3; c++) begin
      @(negedge clock);
      if (vga_plot === 1'b1) got_plots++;
    end
    check("abort_reached_third_plot", got_plots, 3);
    reset = 1'b1;
    set_slot(0, 9'd40, 8'd50, 6'd1, 6'd1, 3'd4, 1'b0);
    set_slot(3, 9'd200, 8'd100, 6'd1, 6'd1, 3'd6, 1'b0);
    req = 4'b1001;
    @(negedge clock);
    check("abort_grant", grant, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_plot", vga_plot, 0);
    check("abort_xyc", {vga_x, vga_y, vga_colour}, 0);
    sb.delete();
    push_box(9'd40, 8'd50, 6'd1, 6'd1, 3'd4);
    push_box(9'd200, 8'd100, 6'd1, 6'd1, 3'd6);
    @(negedge clock);
    check("abort_no_done", done, 0);
    reset = 1'b0;
    serve(2, 16'h0081, 1'b1, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
